wb_framebuffer_regs: RTL and testbench

//  Wishbone slave holding the LED matrix controller's frame-pointer and control registers.
//  It is the responder for the pixel renderers' "swap framebuffer" writes (MATRIX_ADDR_L/H).
//  The pending frame address is double-buffered and applied to the scanner only at a frame boundary.

---
 rtl/wb_framebuffer_regs.sv | 247 ++++++++++++++++++++++++
 tb/tb_wb_framebuffer_regs.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_framebuffer_regs.sv
// ---------------------------------------------------------------------------
// wb_framebuffer_regs
//
// Wishbone slave that holds the LED matrix controller's frame pointer and
// control registers. Pixel renderers "swap framebuffers" by writing the new
// base address into ADDR_L/ADDR_H. That address is held in a pending register
// and handed to the scanner only at a frame boundary. This prevents tearing
// from a half-written pointer or from a swap in the middle of a scan.
//
// Register map (byte offsets from BASE_ADDRESS):
//   0 ADDR_L    RW  pending[7:0]   (a write clears the pending flag)
//   1 ADDR_H    RW  pending[15:8]  (a write sets the pending flag)
//   2 CTRL      RW  [0] enable, [7:4] brightness, [3:1] read as 0
//   3 STATUS    RO  [0] pending flag, [1] enable
//   4 FRAME_CNT RO  frame_sync_i pulse count, wraps at 255
//   5-7         reserved, read as 0, writes acked and ignored
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous reset, active-low
//   adr_i         byte address
//   dat_i         write data
//   dat_o         read data, non-zero only while ack_o is high
//   we_i          1 = write, 0 = read
//   sel_i         byte lane select; a write with sel_i[0]=0 is acked but dropped
//   stb_i, cyc_i  Wishbone strobe and cycle
//   ack_o         one-cycle acknowledge
//   cti_i         cycle type; every beat is treated as a classic cycle
//   frame_sync_i  one-cycle end-of-frame pulse from the scanner
//   frame_addr_o  active framebuffer base address
//   enable_o      scanner enable
//   brightness_o  global brightness
// ---------------------------------------------------------------------------
module wb_framebuffer_regs #(
    parameter int          ADDRESS_WIDTH = 16,
    parameter int          DATA_WIDTH    = 8,
    parameter int          DATA_BYTES    = 1,
    parameter int          BASE_ADDRESS  = 0,
    parameter int          ACK_DELAY     = 1,
    parameter logic [15:0] DEFAULT_FRAME = 16'h0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    output logic [DATA_WIDTH-1:0]    dat_o,
    input  logic                     we_i,
    input  logic [DATA_BYTES-1:0]    sel_i,
    input  logic                     stb_i,
    input  logic                     cyc_i,
    output logic                     ack_o,
    input  logic [2:0]               cti_i,
    input  logic                     frame_sync_i,
    output logic [15:0]              frame_addr_o,
    output logic                     enable_o,
    output logic [3:0]               brightness_o
);

    localparam logic [ADDRESS_WIDTH-1:0] BASE      = ADDRESS_WIDTH'(BASE_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] WINDOW    = ADDRESS_WIDTH'(8);
    localparam logic [2:0]               WAIT_LOAD = 3'(ACK_DELAY - 1);

    localparam logic [2:0] OFF_ADDR_L    = 3'd0;
    localparam logic [2:0] OFF_ADDR_H    = 3'd1;
    localparam logic [2:0] OFF_CTRL      = 3'd2;
    localparam logic [2:0] OFF_STATUS    = 3'd3;
    localparam logic [2:0] OFF_FRAME_CNT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic [ADDRESS_WIDTH-1:0] offset_full;
    logic                     hit;
    logic                     accept;
    logic                     capture;
    logic                     commit;

    logic [2:0]               req_offset;
    logic                     req_we;
    logic [DATA_BYTES-1:0]    req_sel;
    logic [DATA_WIDTH-1:0]    req_dat;
    logic [2:0]               wait_cnt;

    logic [15:0]              pending;
    logic                     pend_flag;
    logic [7:0]               frame_cnt;
    logic [7:0]               read_byte;

    logic                     wr_addr_l;
    logic                     wr_addr_h;
    logic                     wr_ctrl;

    logic                     unused_inputs;

    // The cycle type is accepted but has no effect on how a beat is handled.
    assign unused_inputs = ^cti_i;

    // The offset subtraction is done at full address width, so addresses
    // below BASE wrap to large values and miss instead of aliasing.
    assign offset_full = adr_i - BASE;
    assign hit         = cyc_i & stb_i & (offset_full < WINDOW);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. A dropped cyc_i while waiting abandons
    // the request before anything is captured or committed.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        ack_o      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == 3'd0) begin
                    capture    = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_o      = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Writes take effect on the edge that ends the ack cycle.
    assign commit    = ack_o & req_we & req_sel[0];
    assign wr_addr_l = commit & (req_offset == OFF_ADDR_L);
    assign wr_addr_h = commit & (req_offset == OFF_ADDR_H);
    assign wr_ctrl   = commit & (req_offset == OFF_CTRL);

    // Request latch and wait counter. The request is frozen when accepted so
    // the master may change the bus while we wait.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_offset <= 3'd0;
            req_we     <= 1'b0;
            req_sel    <= '0;
            req_dat    <= '0;
            wait_cnt   <= 3'd0;
        end else if (accept) begin
            req_offset <= offset_full[2:0];
            req_we     <= we_i;
            req_sel    <= sel_i;
            req_dat    <= dat_i;
            wait_cnt   <= WAIT_LOAD;
        end else if (state == ST_WAIT && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Read mux for the latched offset.
    always_comb begin
        read_byte = 8'h00;
        case (req_offset)
            OFF_ADDR_L:    read_byte = pending[7:0];
            OFF_ADDR_H:    read_byte = pending[15:8];
            OFF_CTRL:      read_byte = {brightness_o, 3'b000, enable_o};
            OFF_STATUS:    read_byte = {6'b000000, enable_o, pend_flag};
            OFF_FRAME_CNT: read_byte = frame_cnt;
            default:       read_byte = 8'h00;
        endcase
    end

    // Read data is loaded on entry to the ack cycle and zeroed otherwise, so
    // dat_o is only non-zero while ack_o is high.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dat_o <= '0;
        end else if (capture) begin
            dat_o <= DATA_WIDTH'(read_byte);
        end else begin
            dat_o <= '0;
        end
    end

    // Control register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            enable_o     <= 1'b0;
            brightness_o <= 4'hF;
        end else if (wr_ctrl) begin
            enable_o     <= req_dat[0];
            brightness_o <= req_dat[7:4];
        end
    end

    // Frame pointer double buffer. A bus write to ADDR_H or ADDR_L in the same
    // cycle as frame_sync_i wins over the swap: ADDR_H keeps the swap armed for
    // the next sync, ADDR_L disarms it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending      <= DEFAULT_FRAME;
            pend_flag    <= 1'b0;
            frame_addr_o <= DEFAULT_FRAME;
        end else begin
            if (wr_addr_l) begin
                pending[7:0] <= req_dat[7:0];
            end
            if (wr_addr_h) begin
                pending[15:8] <= req_dat[7:0];
            end
            if (wr_addr_h) begin
                pend_flag <= 1'b1;
            end else if (wr_addr_l) begin
                pend_flag <= 1'b0;
            end else if (frame_sync_i && pend_flag) begin
                frame_addr_o <= pending;
                pend_flag    <= 1'b0;
            end
        end
    end

    // Frame counter runs regardless of bus activity.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            frame_cnt <= 8'h00;
        end else if (frame_sync_i) begin
            frame_cnt <= frame_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_wb_framebuffer_regs.sv
// ---------------------------------------------------------------------------
// tb_wb_framebuffer_regs
//
// Self-checking bench for wb_framebuffer_regs. A behavioural register model
// predicts every read; expected read data is queued when a read is issued
// and compared when the DUT acknowledges it.
// ---------------------------------------------------------------------------
module tb_wb_framebuffer_regs;

    localparam int          CLK_HALF = 5;
    localparam int          ACK_DLY  = 3;
    localparam logic [15:0] BASE     = 16'h0040;
    localparam logic [15:0] DEF_FR   = 16'h1234;

    logic        clk;
    logic        rst_n;
    logic [15:0] adr;
    logic [7:0]  dat_w;
    logic [7:0]  dat_r;
    logic        we;
    logic [0:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic [2:0]  cti;
    logic        frame_sync;
    logic [15:0] frame_addr;
    logic        enable;
    logic [3:0]  brightness;

    int numCompared   = 0;
    int numMismatched = 0;

    // Register model
    logic [15:0] mPending;
    logic [15:0] mFrame;
    logic        mFlag;
    logic        mEnable;
    logic [3:0]  mBright;
    logic [7:0]  mCnt;

    // Scoreboard of expected read data
    logic [7:0]  expQ[$];

    wb_framebuffer_regs #(
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH   (8),
        .DATA_BYTES   (1),
        .BASE_ADDRESS (int'(BASE)),
        .ACK_DELAY    (ACK_DLY),
        .DEFAULT_FRAME(DEF_FR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .adr_i       (adr),
        .dat_i       (dat_w),
        .dat_o       (dat_r),
        .we_i        (we),
        .sel_i       (sel),
        .stb_i       (stb),
        .cyc_i       (cyc),
        .ack_o       (ack),
        .cti_i       (cti),
        .frame_sync_i(frame_sync),
        .frame_addr_o(frame_addr),
        .enable_o    (enable),
        .brightness_o(brightness)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #CLK_HALF clk = ~clk;
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #(CLK_HALF * 2 * 50000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mPending = DEF_FR;
        mFrame   = DEF_FR;
        mFlag    = 1'b0;
        mEnable  = 1'b0;
        mBright  = 4'hF;
        mCnt     = 8'h00;
    endtask

    function automatic logic [7:0] modelRead(input logic [2:0] off);
        case (off)
            3'd0:    return mPending[7:0];
            3'd1:    return mPending[15:8];
            3'd2:    return {mBright, 3'b000, mEnable};
            3'd3:    return {6'b000000, mEnable, mFlag};
            3'd4:    return mCnt;
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelWrite(input logic [2:0] off, input logic [7:0] d);
        case (off)
            3'd0: begin mPending[7:0]  = d; mFlag = 1'b0; end
            3'd1: begin mPending[15:8] = d; mFlag = 1'b1; end
            3'd2: begin mEnable = d[0]; mBright = d[7:4]; end
            default: ;
        endcase
    endtask

    // A pointer write landing on the sync edge suppresses the swap.
    task automatic modelSync(input bit suppress);
        mCnt = mCnt + 8'h01;
        if (!suppress && mFlag) begin
            mFrame = mPending;
            mFlag  = 1'b0;
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_frame_addr"}, 32'(frame_addr), 32'(mFrame));
        checkOutput({tag, "_enable"},     32'(enable),     32'(mEnable));
        checkOutput({tag, "_brightness"}, 32'(brightness), 32'(mBright));
    endtask

    // One Wishbone classic access. Reads push their prediction onto the
    // scoreboard; the ack pops and compares it. Latency is measured in
    // cycles from the first cycle the strobe is presented.
    task automatic applyStimulus(input logic [15:0] a, input bit w, input logic [7:0] d,
                                 input logic sel0, input bit expectAck, input bit syncOnAck);
        logic [15:0] off16;
        logic [2:0]  off;
        logic [7:0]  expData;
        int          lat;
        int          k;
        off16 = a - BASE;
        off   = off16[2:0];
        @(posedge clk);
        #1;
        adr   = a;
        we    = w;
        dat_w = d;
        sel   = sel0;
        cti   = w ? 3'b000 : 3'b111;
        stb   = 1'b1;
        cyc   = 1'b1;
        if (!w && expectAck) expQ.push_back(modelRead(off));
        lat = -1;
        k   = 0;
        while (k < 16 && lat < 0) begin
            @(negedge clk);
            if (ack === 1'b1) lat = k;
            else k++;
        end
        if (expectAck) begin
            checkOutput("ack_latency", 32'(lat), 32'(ACK_DLY + 1));
            if (!w && expQ.size() > 0) begin
                expData = expQ.pop_front();
                if (lat >= 0) checkOutput("read_data", 32'(dat_r), 32'(expData));
            end
            if (lat >= 0) begin
                if (syncOnAck) frame_sync = 1'b1;
                @(posedge clk);
                #1;
                stb        = 1'b0;
                cyc        = 1'b0;
                frame_sync = 1'b0;
                if (w && sel0) modelWrite(off, d);
                if (syncOnAck) modelSync(w && sel0 && (off == 3'd0 || off == 3'd1));
                @(negedge clk);
                checkOutput("ack_one_cycle", 32'(ack), 32'd0);
                checkOutput("dat_after_ack", 32'(dat_r), 32'd0);
            end else begin
                stb = 1'b0;
                cyc = 1'b0;
            end
        end else begin
            checkOutput("no_ack_on_miss", 32'(lat >= 0), 32'd0);
            @(posedge clk);
            #1;
            stb = 1'b0;
            cyc = 1'b0;
        end
    endtask

    // Write that is abandoned by dropping cyc_i while the slave is waiting.
    task automatic applyAbort(input logic [15:0] a, input logic [7:0] d);
        bit seen;
        @(posedge clk);
        #1;
        adr   = a;
        we    = 1'b1;
        dat_w = d;
        sel   = 1'b1;
        stb   = 1'b1;
        cyc   = 1'b1;
        @(posedge clk);
        #1;
        stb   = 1'b0;
        cyc   = 1'b0;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack === 1'b1) seen = 1'b1;
        end
        checkOutput("abort_no_ack", 32'(seen), 32'd0);
    endtask

    task automatic pulseSync(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            frame_sync = 1'b1;
            @(posedge clk);
            #1;
            frame_sync = 1'b0;
            modelSync(1'b0);
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    // Main sequence.
    initial begin
        bit seenAck;
        rst_n      = 1'b0;
        adr        = '0;
        dat_w      = '0;
        we         = 1'b0;
        sel        = 1'b1;
        stb        = 1'b0;
        cyc        = 1'b0;
        cti        = 3'b000;
        frame_sync = 1'b0;
        modelReset();

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_dat", 32'(dat_r), 32'd0);
        checkState("rst");
        rst_n = 1'b1;
        applyStimulus(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Basic swap
        applyStimulus(BASE + 16'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd1, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkState("pre_swap");
        pulseSync(1);
        checkState("post_swap");
        checkOutput("swap_addr", 32'(frame_addr), 32'h0400);
        applyStimulus(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Control register, reserved bits read back as zero
        applyStimulus(BASE + 16'd2, 1'b1, 8'hAF, 1'b1, 1'b1, 1'b0);
        checkState("ctrl_write");
        applyStimulus(BASE + 16'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // ADDR_H commit colliding with sync: swap deferred to next sync
        applyStimulus(BASE + 16'd0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
        checkState("collide_h");
        applyStimulus(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        pulseSync(1);
        checkState("deferred_swap");
        checkOutput("deferred_addr", 32'(frame_addr), 32'h2280);

        // ADDR_L after ADDR_H disarms the swap
        applyStimulus(BASE + 16'd1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        pulseSync(1);
        checkState("disarmed");

        // ADDR_L commit colliding with sync cancels the swap
        applyStimulus(BASE + 16'd1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
        applyStimulus(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        pulseSync(1);
        checkState("collide_l");

        // Decode boundaries and dropped lane
        applyStimulus(BASE + 16'd8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(BASE - 16'd1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(BASE + 16'd2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd5, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd7, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Aborted write leaves CTRL untouched
        applyAbort(BASE + 16'd2, 8'h00);
        applyStimulus(BASE + 16'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkState("after_abort");

        // Frame counter wrap
        doReset();
        pulseSync(255);
        applyStimulus(BASE + 16'd4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        pulseSync(1);
        applyStimulus(BASE + 16'd4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a waiting read
        applyStimulus(BASE + 16'd2, 1'b1, 8'h31, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        pulseSync(1);
        checkState("pre_reset");
        @(posedge clk);
        #1;
        adr = BASE + 16'd2;
        we  = 1'b0;
        sel = 1'b1;
        stb = 1'b1;
        cyc = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midwait_rst_ack", 32'(ack), 32'd0);
        checkOutput("midwait_rst_dat", 32'(dat_r), 32'd0);
        checkState("midwait_rst");
        stb = 1'b0;
        cyc = 1'b0;
        seenAck = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack === 1'b1) seenAck = 1'b1;
        end
        rst_n = 1'b1;
        checkOutput("midwait_no_ack", 32'(seenAck), 32'd0);
        applyStimulus(BASE + 16'd3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(BASE + 16'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
